apb_i2c_regs: RTL and testbench

//  Parametrised APB register file bridging the APB host to the I2C core and its TX/RX FIFOs.

---
 rtl/apb_i2c_regs.sv | 178 +++++++++++++++++
 tb/tb_apb_i2c_regs.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_regs.sv
// APB register file for the I2C core: configuration/control registers,
// TX push / RX pop FIFO handshakes, TXDATA wait states with timeout,
// pslverr reporting and a registered, maskable interrupt.
module apb_i2c_regs #(
  parameter int          DATA_W  = 8,
  parameter int          ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] config_reg,
  output logic [DATA_W-1:0] control_reg,
  output logic              tx_push,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_full,
  input  logic              tx_empty,
  output logic              rx_pop,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_empty,
  input  logic              i2c_done,
  input  logic              i2c_nack,
  output logic              irq
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] A_CONFIG   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_CONTROL  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TXDATA   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_RXDATA   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_IRQ_EN   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_IRQ_STAT = ADDR_W'(6);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_WAIT} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [DATA_W-1:0] r_config;
  logic [DATA_W-1:0] r_control;
  logic [DATA_W-1:0] r_irq_en;
  logic [DATA_W-1:0] r_irq_stat;
  logic              r_tx_empty_d;
  logic              r_rx_empty_d;
  logic              r_irq;

  logic              w_access;
  logic              w_tx_wr;
  logic              w_stall;
  logic              w_done;
  logic              w_wr_done;
  logic              w_err;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_w1c;
  logic [DATA_W-1:0] w_evt;

  // Qualifying the access phase with presetn keeps every side effect and
  // every combinational response silent while reset is held.
  assign w_access  = psel & penable & presetn;
  assign w_tx_wr   = w_access & pwrite & (paddr == A_TXDATA);
  assign w_stall   = w_tx_wr & tx_full & (r_wait_cnt < CNT_W'(TIMEOUT));
  assign w_done    = w_access & ~w_stall;
  assign w_wr_done = w_done & pwrite;

  assign pready      = ~w_stall;
  assign pslverr     = w_done & w_err;
  assign prdata      = (w_done & ~pwrite) ? w_rdata : '0;
  assign tx_push     = w_tx_wr & ~tx_full;
  assign tx_data     = pwdata;
  assign rx_pop      = w_done & ~pwrite & (paddr == A_RXDATA) & ~rx_empty;
  assign config_reg  = r_config;
  assign control_reg = r_control;
  assign irq         = r_irq;

  // STATUS bit3 and IRQ_STAT bit4 share identical set/clear rules, so a
  // single flop (r_irq_stat[4]) backs both views.
  always_comb begin
    w_status    = '0;
    w_status[0] = tx_full;
    w_status[1] = tx_empty;
    w_status[2] = rx_empty;
    w_status[3] = r_irq_stat[4];
  end

  // Address decode: read data and error response for the current access.
  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (paddr)
      A_CONFIG:   w_rdata = r_config;
      A_CONTROL:  w_rdata = r_control;
      A_TXDATA:   w_err   = pwrite & tx_full;
      A_STATUS:   w_rdata = w_status;
      A_RXDATA: begin
        if (!pwrite) begin
          if (rx_empty) w_err   = 1'b1;
          else          w_rdata = rx_data;
        end
      end
      A_IRQ_EN:   w_rdata = r_irq_en;
      A_IRQ_STAT: w_rdata = r_irq_stat;
      default:    w_err   = 1'b1;
    endcase
  end

  // Interrupt event sources and the W1C mask from an IRQ_STAT write.
  always_comb begin
    w_evt    = '0;
    w_evt[0] = tx_empty & ~r_tx_empty_d;
    w_evt[1] = ~rx_empty & r_rx_empty_d;
    w_evt[2] = i2c_done;
    w_evt[3] = i2c_nack;
    w_evt[4] = w_done & w_err;
    w_w1c    = (w_wr_done && paddr == A_IRQ_STAT) ? pwdata : '0;
  end

  // APB phase tracker and TXDATA wait-state counter.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else if (!psel) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_stall ? r_wait_cnt + CNT_W'(1) : '0;
      case (r_state)
        S_IDLE:   if (!penable) r_state <= S_SETUP;
        S_SETUP:  r_state <= S_ACCESS;
        S_ACCESS: begin
          if (w_stall)       r_state <= S_WAIT;
          else if (!penable) r_state <= S_SETUP;
          else               r_state <= S_IDLE;
        end
        S_WAIT:   if (!w_stall) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Writable registers, commit at the completing edge.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_config  <= '0;
      r_control <= '0;
      r_irq_en  <= '0;
    end else if (w_wr_done) begin
      if (paddr == A_CONFIG)  r_config  <= pwdata;
      if (paddr == A_CONTROL) r_control <= pwdata;
      if (paddr == A_IRQ_EN)  r_irq_en  <= pwdata;
    end
  end

  // Interrupt status (set beats W1C), edge detectors and registered irq.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_irq_stat   <= '0;
      r_tx_empty_d <= 1'b0;
      r_rx_empty_d <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_irq_stat   <= (r_irq_stat & ~w_w1c) | w_evt;
      r_tx_empty_d <= tx_empty;
      r_rx_empty_d <= rx_empty;
      r_irq        <= |(r_irq_stat & r_irq_en);
    end
  end

endmodule

// File: tb/tb_apb_i2c_regs.sv
module tb_apb_i2c_regs;

  logic       pclk = 1'b0;
  logic       presetn, psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata, config_reg, control_reg, tx_data, rx_data;
  logic       pready, pslverr, tx_push, tx_full, tx_empty, rx_pop, rx_empty;
  logic       i2c_done, i2c_nack, irq;

  apb_i2c_regs #(.DATA_W(8), .ADDR_W(8), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .config_reg(config_reg),
    .control_reg(control_reg), .tx_push(tx_push), .tx_data(tx_data),
    .tx_full(tx_full), .tx_empty(tx_empty), .rx_pop(rx_pop),
    .rx_data(rx_data), .rx_empty(rx_empty), .i2c_done(i2c_done),
    .i2c_nack(i2c_nack), .irq(irq)
  );

  always #5 pclk = ~pclk;

  int compared = 0;
  int mismatched = 0;
  int push_cnt = 0;
  int pop_cnt = 0;

  // Reference model state
  logic [7:0] m_cfg, m_ctrl, m_en, m_stat;

  always @(posedge pclk) begin
    if (tx_push === 1'b1) push_cnt++;
    if (rx_pop === 1'b1) pop_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status();
    return {3'b000, m_stat[4], rx_empty, tx_empty, tx_full};
  endfunction

  function automatic logic [7:0] exp_read(input logic [7:0] a);
    case (a)
      8'd0:    return m_cfg;
      8'd1:    return m_ctrl;
      8'd3:    return exp_status();
      8'd5:    return m_en;
      8'd6:    return m_stat;
      default: return 8'h00;
    endcase
  endfunction

  // One APB transfer; release_after>0 drops tx_full after that many wait states.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] data,
                     input int release_after, input logic done_pulse,
                     output logic [7:0] rdata, output logic err, output int waits,
                     output logic push_seen);
    rdata = '0; err = 1'b0; push_seen = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    if (done_pulse) i2c_done = 1'b1;
    waits = 0;
    forever begin
      @(negedge pclk);
      if (pready === 1'b1) begin
        rdata = prdata; err = pslverr; push_seen = tx_push;
        break;
      end
      waits++;
      @(posedge pclk); #1;
      if (waits == release_after) tx_full = 1'b0;
      if (waits > 200) begin
        compared++; mismatched++;
        $error("FAIL wait_bound: observed %0d waits expected completion", waits);
        break;
      end
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; i2c_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  logic [7:0] rd;
  logic       er, ps;
  int         wt, p0;
  logic [7:0] a, d;

  initial begin
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = 8'h3D; rx_data = '0;
    tx_full = 1'b0; tx_empty = 1'b0; rx_empty = 1'b1;
    i2c_done = 1'b0; i2c_nack = 1'b0;
    m_cfg = '0; m_ctrl = '0; m_en = '0; m_stat = '0;
    idle(3);
    check("rst_pready", pready, 1);
    check("rst_pslverr", pslverr, 0);
    check("rst_prdata", prdata, 0);
    check("rst_config", config_reg, 0);
    check("rst_irq", irq, 0);
    check("rst_tx_data", tx_data, 8'h3D);
    presetn = 1'b1;
    idle(2);

    // Basic RW registers, zero wait states
    apb(1, 8'd0, 8'hA5, 0, 0, rd, er, wt, ps); m_cfg = 8'hA5;
    check("cfg_wr_waits", wt, 0);
    apb(1, 8'd1, 8'h3C, 0, 0, rd, er, wt, ps); m_ctrl = 8'h3C;
    check("config_reg_out", config_reg, 8'hA5);
    apb(0, 8'd0, 8'h00, 0, 0, rd, er, wt, ps);
    check("cfg_rd", rd, 8'hA5); check("cfg_rd_err", er, 0); check("cfg_rd_waits", wt, 0);
    apb(0, 8'd1, 8'h00, 0, 0, rd, er, wt, ps);
    check("ctrl_rd", rd, 8'h3C); check("ctrl_rd_err", er, 0);
    apb(0, 8'd2, 8'h00, 0, 0, rd, er, wt, ps);
    check("txdata_rd", rd, 0); check("txdata_rd_err", er, 0);

    // TXDATA write stalled by tx_full for 3 cycles
    tx_full = 1'b1; p0 = push_cnt;
    apb(1, 8'd2, 8'h55, 3, 0, rd, er, wt, ps);
    check("tx_stall_waits", wt, 3);
    check("tx_stall_push", ps, 1);
    check("tx_stall_err", er, 0);
    check("tx_push_count", push_cnt - p0, 1);
    check("tx_data", tx_data, 8'h55);

    // TXDATA write times out
    tx_full = 1'b1; p0 = push_cnt;
    apb(1, 8'd2, 8'h66, 0, 0, rd, er, wt, ps); m_stat |= 8'h10;
    check("tx_to_waits", wt, 16);
    check("tx_to_err", er, 1);
    check("tx_to_push", push_cnt - p0, 0);
    apb(0, 8'd3, 8'h00, 0, 0, rd, er, wt, ps);
    check("status_sticky", rd, exp_status());
    check("status_bit3", rd[3], 1);
    tx_full = 1'b0;

    // RXDATA pop
    rx_data = 8'h7E; rx_empty = 1'b0; m_stat |= 8'h02; p0 = pop_cnt;
    idle(2);
    apb(0, 8'd4, 8'h00, 0, 0, rd, er, wt, ps);
    check("rx_rd", rd, 8'h7E); check("rx_rd_err", er, 0); check("rx_pop", pop_cnt - p0, 1);
    rx_empty = 1'b1; p0 = pop_cnt;
    apb(0, 8'd4, 8'h00, 0, 0, rd, er, wt, ps); m_stat |= 8'h10;
    check("rx_empty_rd", rd, 0); check("rx_empty_err", er, 1); check("rx_empty_pop", pop_cnt - p0, 0);

    // Interrupt: clear status, enable bit2, pulse i2c_done
    apb(1, 8'd6, 8'hFF, 0, 0, rd, er, wt, ps); m_stat = '0;
    apb(1, 8'd5, 8'h04, 0, 0, rd, er, wt, ps); m_en = 8'h04;
    idle(2);
    check("irq_idle", irq, 0);
    i2c_done = 1'b1; @(posedge pclk); #1 i2c_done = 1'b0; m_stat |= 8'h04;
    @(negedge pclk); check("irq_1cyc", irq, 0);
    @(negedge pclk); check("irq_2cyc", irq, 1);
    apb(1, 8'd6, 8'h04, 0, 1, rd, er, wt, ps); m_stat = (m_stat & ~8'h04) | 8'h04;
    apb(0, 8'd6, 8'h00, 0, 0, rd, er, wt, ps);
    check("w1c_set_wins", rd, m_stat);
    apb(1, 8'd6, 8'h04, 0, 0, rd, er, wt, ps); m_stat &= ~8'h04;
    idle(2);
    check("irq_cleared", irq, 0);

    // Randomized register traffic against the model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(5, 0))
        0: begin
          case ($urandom_range(3, 0))
            0: a = 8'd0; 1: a = 8'd1; 2: a = 8'd5; default: a = 8'd6;
          endcase
          d = 8'($urandom);
          apb(1, a, d, 0, 0, rd, er, wt, ps);
          check("rnd_wr_err", er, 0);
          case (a)
            8'd0: m_cfg = d; 8'd1: m_ctrl = d; 8'd5: m_en = d;
            default: m_stat &= ~d;
          endcase
        end
        1: begin
          case ($urandom_range(5, 0))
            0: a = 8'd0; 1: a = 8'd1; 2: a = 8'd2; 3: a = 8'd3; 4: a = 8'd5; default: a = 8'd6;
          endcase
          apb(0, a, 8'h00, 0, 0, rd, er, wt, ps);
          check("rnd_rd", rd, exp_read(a));
          check("rnd_rd_err", er, 0);
        end
        2: begin
          a = 8'($urandom_range(255, 7));
          apb(1'($urandom), a, 8'($urandom), 0, 0, rd, er, wt, ps); m_stat |= 8'h10;
          check("rnd_bad_err", er, 1);
          check("rnd_bad_rd", rd, 0);
        end
        3: begin
          if (!tx_empty) m_stat |= 8'h01;
          tx_empty = ~tx_empty;
          idle(1);
        end
        4: begin
          if (rx_empty) m_stat |= 8'h02;
          rx_empty = ~rx_empty;
          idle(1);
        end
        default: begin
          i2c_nack = 1'b1; idle(1); i2c_nack = 1'b0; m_stat |= 8'h08;
        end
      endcase
      idle(2);
      check("rnd_irq", irq, |(m_stat & m_en));
    end
    apb(0, 8'd6, 8'h00, 0, 0, rd, er, wt, ps);
    check("rnd_stat_final", rd, m_stat);
    apb(0, 8'd3, 8'h00, 0, 0, rd, er, wt, ps);
    check("rnd_status_final", rd, exp_status());

    // Reset in the middle of a stalled TXDATA write
    apb(1, 8'd5, 8'h1F, 0, 0, rd, er, wt, ps);
    apb(1, 8'd0, 8'h5A, 0, 0, rd, er, wt, ps);
    i2c_done = 1'b1; idle(1); i2c_done = 1'b0;
    idle(2);
    check("pre_rst_irq", irq, 1);
    tx_full = 1'b1; p0 = push_cnt;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd2; pwdata = 8'h99;
    @(posedge pclk); #1 penable = 1'b1;
    repeat (3) @(posedge pclk);
    #3 presetn = 1'b0;
    #1;
    check("midrst_pready", pready, 1);
    check("midrst_pslverr", pslverr, 0);
    check("midrst_push", tx_push, 0);
    check("midrst_pop", rx_pop, 0);
    check("midrst_prdata", prdata, 0);
    check("midrst_config", config_reg, 0);
    check("midrst_irq", irq, 0);
    check("midrst_tx_data", tx_data, 8'h99);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; tx_full = 1'b0;
    @(posedge pclk); #1 presetn = 1'b1;
    m_cfg = '0; m_ctrl = '0; m_en = '0; m_stat = '0;
    idle(2);
    check("midrst_no_push", push_cnt - p0, 0);
    apb(0, 8'd6, 8'h00, 0, 0, rd, er, wt, ps);
    check("post_rst_stat", rd, m_stat);
    apb(1, 8'd7, 8'h12, 0, 0, rd, er, wt, ps);
    check("bad_addr7_err", er, 1);
    apb(0, 8'd0, 8'h00, 0, 0, rd, er, wt, ps);
    check("bad_addr7_ignored", rd, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
